// File: rtl/led_pkg.sv
// Shared definitions for the LED bar chaser/monitor pair: FSM state encoding
// (identical to the dir output encoding), default bar width and level width.
package led_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_SYNC = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 16;

  // Bits needed to hold a lit-LED count in 0..w.
  function automatic int lvl_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/led_bar_monitor_therm_decode.sv
// Combinational thermometer-to-binary decode of the LED bar with a
// legality flag (bar must be a contiguous run of ones from bit 0).
module therm_decode #(
  parameter int WIDTH = 16,
  parameter int LVL_W = 5
) (
  input  logic [WIDTH-1:0] led_i,
  output logic [LVL_W-1:0] level_o,
  output logic             legal_o
);

  logic [WIDTH-1:0] led_inc;

  // A legal code plus one is a power of two (or wraps to zero), so it
  // shares no set bit with the original code.
  assign led_inc = led_i + 1'b1;
  assign legal_o = ((led_i & led_inc) == '0);

  always_comb begin
    // NOTE: blocking assignments are correct inside always_comb; the
    // accumulator is a running sum within one evaluation, not state.
    level_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level_o = level_o + LVL_W'(led_i[i]);
    end
  end

endmodule

// File: rtl/led_bar_monitor.sv
// Receive-side monitor for the LED chaser: decodes the thermometer bar,
// tracks the up/down sequence and reports turn-around and error events.
module led_bar_monitor
  import led_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LVL_W = lvl_width(WIDTH),
  parameter int IDX_W = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] led,
  output logic [LVL_W-1:0] level,
  output logic             level_valid,
  output logic [1:0]       dir,
  output logic [IDX_W-1:0] seg_index,
  output logic             peak_pulse,
  output logic             valley_pulse,
  output logic             flick_pulse,
  output logic             seq_done,
  output logic             code_err,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic signed [LVL_W:0] D_ZERO = '0;
  localparam logic signed [LVL_W:0] D_UP   = (LVL_W + 1)'(1);
  localparam logic signed [LVL_W:0] D_DOWN = (LVL_W + 1)'(-1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] prev_q, prev_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] seg_q, seg_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             peak_q, peak_d, valley_q, valley_d, flick_q, flick_d;
  logic             done_q, done_d, code_q, code_d, step_q, step_d;

  logic [LVL_W-1:0]  n;
  logic              legal;
  logic signed [LVL_W:0] delta;
  logic [ERR_W-1:0]  err_inc;

  therm_decode #(
    .WIDTH(WIDTH),
    .LVL_W(LVL_W)
  ) u_decode (
    .led_i  (led),
    .level_o(n),
    .legal_o(legal)
  );

  assign delta   = $signed({1'b0, n}) - $signed({1'b0, prev_q});
  assign err_inc = (err_q == '1) ? err_q : err_q + 1'b1;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    prev_d   = prev_q;
    level_d  = level_q;
    valid_d  = valid_q;
    seg_d    = seg_q;
    err_d    = err_q;
    peak_d   = 1'b0;
    valley_d = 1'b0;
    flick_d  = 1'b0;
    done_d   = 1'b0;
    code_d   = 1'b0;
    step_d   = 1'b0;

    if (clear) begin
      err_d   = '0;
      state_d = S_SYNC;
    end else if (sample_en) begin
      if (!legal) begin
        code_d  = 1'b1;
        err_d   = err_inc;
        valid_d = 1'b0;
        state_d = S_SYNC;
      end else begin
        level_d = n;
        valid_d = 1'b1;
        prev_d  = n;
        unique case (state_q)
          S_SYNC: begin
            if (n == '0) state_d = S_IDLE;
          end
          S_IDLE: begin
            if (delta == D_UP) begin
              flick_d = 1'b1;
              seg_d   = '0;
              state_d = S_UP;
            end else if (delta != D_ZERO) begin
              step_d  = 1'b1;
              state_d = S_SYNC;
            end
          end
          S_UP: begin
            if (delta == D_ZERO) begin
              peak_d  = 1'b1;
              seg_d   = seg_q + 1'b1;
              state_d = S_DOWN;
            end else if (delta != D_UP) begin
              step_d  = 1'b1;
              state_d = S_SYNC;
            end
          end
          S_DOWN: begin
            if (delta == D_ZERO && n != '0) begin
              valley_d = 1'b1;
              seg_d    = seg_q + 1'b1;
              state_d  = S_UP;
            end else if (delta == D_ZERO) begin
              done_d  = 1'b1;
              seg_d   = '0;
              state_d = S_IDLE;
            end else if (delta == D_UP) begin
              flick_d = 1'b1;
              seg_d   = (seg_q == '0) ? '0 : seg_q - 1'b1;
              state_d = S_UP;
            end else if (delta != D_DOWN) begin
              step_d  = 1'b1;
              state_d = S_SYNC;
            end
          end
          default: state_d = S_SYNC;
        endcase
        if (step_d) err_d = err_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all
    // registers sample their next values from the same pre-edge state.
    if (!reset) begin
      state_q  <= S_SYNC;
      prev_q   <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      seg_q    <= '0;
      err_q    <= '0;
      peak_q   <= 1'b0;
      valley_q <= 1'b0;
      flick_q  <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      seg_q    <= seg_d;
      err_q    <= err_d;
      peak_q   <= peak_d;
      valley_q <= valley_d;
      flick_q  <= flick_d;
      done_q   <= done_d;
      code_q   <= code_d;
      step_q   <= step_d;
    end
  end

  assign level        = level_q;
  assign level_valid  = valid_q;
  assign dir          = state_q;
  assign seg_index    = seg_q;
  assign peak_pulse   = peak_q;
  assign valley_pulse = valley_q;
  assign flick_pulse  = flick_q;
  assign seq_done     = done_q;
  assign code_err     = code_q;
  assign step_err     = step_q;
  assign err_count    = err_q;

endmodule

// File: doc/led_bar_monitor.md
Name: led_bar_monitor

Overview:
Observes the 16-LED thermometer bar driven by the LED chaser and decodes it back into level, direction and sequence events. It is the receive-side counterpart of the chaser: the chaser encodes a level as a thermometer code, and this block decodes and validates that code. It sits beside the chaser, on-chip or on a test header. It supplies self-check, status and error counters to the board controller.

Parameters:
WIDTH, 16, number of LEDs in the bar
LVL_W, 5, width of decoded level; must satisfy 2^LVL_W > WIDTH
IDX_W, 3, width of segment index counter
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock
reset  input  1  async active-low reset
sample_en  input  1  qualifies an LED sample; one sample per chaser step
clear  input  1  sync: zero err_count, force S_SYNC
led  input  WIDTH  thermometer bar from chaser
level  output  LVL_W  decoded number of lit LEDs
level_valid  output  1  level reflects a legal code
dir  output  2  0 IDLE, 1 UP, 2 DOWN, 3 SYNC (mirrors state)
seg_index  output  IDX_W  up/down segment count since sequence start
peak_pulse  output  1  one-cycle pulse: upward turn-around detected
valley_pulse  output  1  one-cycle pulse: downward turn-around at nonzero level
flick_pulse  output  1  one-cycle pulse: reversal without hold (flick)
seq_done  output  1  one-cycle pulse: sequence returned to 0 and held
code_err  output  1  one-cycle pulse: non-thermometer sample
step_err  output  1  one-cycle pulse: illegal level step
err_count  output  ERR_W  saturating count of code_err plus step_err

Behaviour:
- Reset values: all outputs 0, except dir=3. State=S_SYNC, prev=0.
- All processing occurs only on cycles with sample_en=1. Otherwise all registers hold and pulses are 0.
- Latency: outputs are registered and update one cycle after the sample_en edge.
- Decode: a code is legal iff led == (1<<n)-1 for some n in 0..WIDTH. In that case level=n and level_valid=1.
- Illegal code:
  - code_err=1, err_count+1 (saturating), level_valid=0.
  - level and prev hold; state goes to S_SYNC.
- Definitions: delta = n - prev, computed signed at LVL_W+1 bits. prev<=n on every legal sample.
- State S_SYNC: stay until n==0, then go to S_IDLE. No events and no step checking in S_SYNC.
- State S_IDLE:
  - delta 0: stay.
  - delta +1: flick_pulse, seg_index=0, go to S_UP.
  - other delta: step_err, go to S_SYNC.
- State S_UP:
  - delta +1: stay.
  - delta 0: peak_pulse, seg_index+1, go to S_DOWN.
  - other delta: step_err, go to S_SYNC.
- State S_DOWN:
  - delta -1: stay.
  - delta 0 with n>0: valley_pulse, seg_index+1, go to S_UP.
  - delta 0 with n==0: seq_done, seg_index=0, go to S_IDLE.
  - delta +1: flick_pulse, seg_index-1 (saturating at 0), go to S_UP.
  - other delta: step_err, go to S_SYNC.
- The chaser's own jump from any level straight to 0 at sequence end is flagged as step_err and recovered through S_SYNC, unless the level is already 0.
- seg_index wraps modulo 2^IDX_W on increment.
- step_err and code_err also saturate err_count. Both cannot occur on the same sample.
- clear has priority over sample processing in the same cycle: err_count=0, state goes to S_SYNC, pulses are 0.
- Reset mid-sequence returns the block to S_SYNC. The monitor then re-acquires at the next level-0 sample.
- A level at WIDTH followed by delta 0 is a normal peak. No separate overflow condition exists.

Decomposition:
- Shared package led_pkg: state encoding (S_IDLE=0, S_UP=1, S_DOWN=2, S_SYNC=3, identical to dir), the WIDTH default, and a level-width function.
- One sub-module, therm_decode: combinational thermometer-to-binary decode plus legality flag.
- FSM, counters and pulses live in the top.

Test Plan:
1. After reset, drive samples 0 and 0 -> dir=0 on the second sample, level=0, level_valid=1.
2. Drive sample sequence 0,1,2,...,16,16,15,...,6,6,7 -> flick_pulse on 1. Then peak_pulse at the second 16 (seg_index=1), valley_pulse at the second 6 (seg_index=2), dir=1 after the 7.
3. In S_DOWN at level 8, drive 9 -> flick_pulse, seg_index decrements by 1, dir=1. Next 10 produces no error.
4. Drive a descent 3,2,1,0,0 -> seq_done on the second 0, seg_index=0, dir=0.
5. Drive led=16'h00F5 -> code_err, err_count=1, level_valid=0, dir=3. Then 0 -> dir=0.
6. At level 5 in S_UP, drive 9 -> step_err, err_count increments. Assert clear in the same cycle as a sample -> err_count=0, no pulse.
